// File: rtl/whack_pkg.sv
// Shared types and width helpers for the whack-a-mole judge.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        COOLDOWN
    } state_t;

    localparam int DEFAULT_POS_W   = 2;
    localparam int DEFAULT_SCORE_W = 8;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector; the history register resets high so a key held through reset is not a press.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) level_q <= 1'b1;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/hit_judge.sv
// Judges one mole appearance at a time: hit, miss or timeout, with saturating score and lives.
module hit_judge
    import whack_pkg::*;
#(
    parameter int POS_W   = DEFAULT_POS_W,
    parameter int WINDOW  = 50000000,
    parameter int HOLD    = 25000000,
    parameter int LIVES   = 3,
    parameter int SCORE_W = DEFAULT_SCORE_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            space,
    input  logic                            mole_valid,
    input  logic [POS_W-1:0]                mole_pos,
    input  logic [POS_W-1:0]                sel_pos,
    output logic                            mole_on,
    output logic [POS_W-1:0]                mole_q,
    output logic                            busy,
    output logic                            hit,
    output logic                            miss,
    output logic                            timeout,
    output logic                            out,
    output logic [SCORE_W-1:0]              score,
    output logic [width_of(LIVES+1)-1:0]    lives_left,
    output logic                            game_over
);

    localparam int TW = width_of(max_of(WINDOW, HOLD));
    localparam int LW = width_of(LIVES + 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic          press;

    key_edge u_space_edge (
        .clk  (clk),
        .reset(reset),
        .level(space),
        .rise (press)
    );

    // mole_on/busy/out are kept as registers updated on each transition, so every
    // output comes straight from a flop rather than a decode of state.
    // NOTE: all state here uses non-blocking assignments so every branch reads the
    // pre-edge values of lives_left/timer; blocking would leak same-cycle updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            mole_q     <= '0;
            mole_on    <= 1'b0;
            busy       <= 1'b0;
            out        <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            timeout    <= 1'b0;
            score      <= '0;
            lives_left <= LW'(LIVES);
            game_over  <= 1'b0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (mole_valid && !game_over) begin
                        mole_q  <= mole_pos;
                        timer   <= TW'(WINDOW - 1);
                        state   <= ACTIVE;
                        mole_on <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                ACTIVE: begin
                    if (press && sel_pos == mole_q) begin
                        hit     <= 1'b1;
                        if (score != '1) score <= score + 1'b1;
                        timer   <= TW'(HOLD - 1);
                        state   <= COOLDOWN;
                        mole_on <= 1'b0;
                        out     <= 1'b1;
                    end else if (press || timer == '0) begin
                        // A miss shadows a coinciding expiry; either costs exactly one life.
                        miss    <= press;
                        timeout <= ~press;
                        if (lives_left != '0) lives_left <= lives_left - 1'b1;
                        if (lives_left <= LW'(1)) game_over <= 1'b1;
                        if (lives_left <= LW'(1) || timer == '0) begin
                            state   <= IDLE;
                            mole_on <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                COOLDOWN: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        out   <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    mole_on <= 1'b0;
                    busy    <= 1'b0;
                    out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
Parametrised successor to the single-cycle space/position comparator for the whack-a-mole game. Judges one mole appearance at a time and detects space-key rising edges. Classifies each appearance as hit, miss (wrong hole pressed) or timeout within a programmable window. Keeps a saturating score and a lives counter, and sits between the mole generator and the display/score logic.

Parameters:
POS_W, 2, hole index width; 2**POS_W holes
WINDOW, 50000000, cycles a mole stays up (>=1)
HOLD, 25000000, cycles the hit indication is held after a hit (>=1)
LIVES, 3, misses+timeouts allowed before game over (>=1)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
space  in  1  space key level, already synchronised to clk
mole_valid  in  1  request to raise a new mole (pulse or level)
mole_pos  in  POS_W  hole for the new mole, sampled with mole_valid
sel_pos  in  POS_W  player cursor hole
mole_on  out  1  mole currently up (state ACTIVE)
mole_q  out  POS_W  latched hole of current mole
busy  out  1  state != IDLE
hit  out  1  one-cycle pulse, correct hole pressed
miss  out  1  one-cycle pulse, wrong hole pressed while mole up
timeout  out  1  one-cycle pulse, window expired without hit
out  out  1  high throughout COOLDOWN (hit display)
score  out  SCORE_W  hits, saturating
lives_left  out  clog2(LIVES+1)  remaining lives
game_over  out  1  sticky until reset

Behaviour:
- Single clock domain: clk, synchronous active-high reset; all outputs registered.
- Reset values: state IDLE; mole_q, hit, miss, timeout, out, score, game_over all 0; lives_left=LIVES; timer 0; space_q=1, so a key held through reset is not a press.
- press = space & ~space_q; space_q <= space every cycle.
- Pulse latency: if space is sampled high at edge k with space_q=0, the hit/miss pulse is high for exactly the cycle after edge k.
- IDLE: if mole_valid & ~game_over: mole_q<=mole_pos, timer<=WINDOW-1, go ACTIVE. press ignored. mole_valid ignored when game_over=1.
- ACTIVE priority, evaluated each edge:
  1. press & sel_pos==mole_q -> hit; score+1, saturating at 2**SCORE_W-1; timer<=HOLD-1; go COOLDOWN. Hit wins over simultaneous timer expiry.
  2. press & mismatch -> miss; lives_left-1. If this reaches 0: game_over<=1, go IDLE. Otherwise stay ACTIVE; the timer keeps running, not restarted.
  3. timer==0 -> timeout; lives_left-1; game_over<=1 if it reaches 0; go IDLE.
  4. Otherwise timer-1.
- A miss and a timeout in the same cycle: only the miss is reported (priority 2 over 3); one life is lost, and the state goes IDLE if timer==0.
- mole_valid during ACTIVE or COOLDOWN is ignored (no queueing).
- COOLDOWN: out=1. Count timer down; at 0 go IDLE. press ignored.
- lives_left never underflows. At most one of hit/miss/timeout is high in any cycle.
- Reset mid-operation returns everything to reset values on the next edge; no pulse is emitted on that edge.
- Widths: timer width clog2(max(WINDOW,HOLD)).

Decomposition:
- Package whack_pkg: state enum (IDLE, ACTIVE, COOLDOWN), default POS_W/SCORE_W constants, and a clog2-based width helper.
- Sub-module key_edge: rising-edge detector with reset-to-1 register; the player-input blocks reuse it.
- Timer and counters stay inline.

Test Plan:
Use POS_W=2, WINDOW=8, HOLD=3, LIVES=3, SCORE_W=2 throughout.
1. Hit: mole_valid with mole_pos=2; sel_pos=2; space rises 3 cycles later -> one-cycle hit on the next cycle; score=1; out high 3 cycles; busy drops; state IDLE.
2. Miss then hit: mole_pos=1, sel_pos=3, press -> miss, lives_left=2, mole_on stays 1. Then sel_pos=1, press within the window -> hit, score=1.
3. Timeout: mole_pos=0 with no press -> timeout exactly 9 cycles after mole_valid is sampled; lives_left=2; mole_on=0. Three timeouts -> game_over=1; a further mole_valid is ignored (busy stays 0).
4. Edge cases:
   - space held high across 3 moles -> no hit/miss after the first edge.
   - space held during reset, then released-free high -> no press.
   - press with sel_pos matching on the exact timer==0 cycle -> hit, no timeout.
5. Saturation: 5 consecutive hits -> score sticks at 3. mole_valid during COOLDOWN -> ignored; mole_q unchanged.
6. Reset during ACTIVE and during COOLDOWN -> next cycle all outputs at reset values, lives_left=3, no pulse.
